onebit_sdr_tx: RTL and testbench

//  Transmit-side counterpart of the 1-bit SDR sampler: reads OSR-count sample words from an

---
 rtl/onebit_sdr_tx.sv | 149 ++++++++++++++
 tb/tb_onebit_sdr_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/onebit_sdr_tx.sv
// Transmit side of the 1-bit SDR link: pulls sample words from an async FIFO once per
// OSR-cycle window and turns each sample into a 1-bit density stream with a first-order modulator.
module onebit_sdr_tx #(
    parameter int DSIZE       = 16,
    parameter int SAMPLE_W    = 5,
    parameter int OSR_LOG2    = 2,
    parameter int IDLE_SAMPLE = 2
) (
    input  logic             clk_data,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_rempty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_rinc,
    output logic             rf_out_1bit,
    output logic             running,
    output logic [15:0]      underrun_count,
    output logic             sat_flag
);

    localparam int OSR = 1 << OSR_LOG2;
    localparam logic [OSR_LOG2-1:0] PH_DECIDE = OSR_LOG2'(OSR - 2);
    localparam logic [OSR_LOG2-1:0] PH_READ   = OSR_LOG2'(OSR - 1);
    localparam logic [SAMPLE_W:0]   OSR_T     = (SAMPLE_W + 1)'(OSR);
    localparam logic [SAMPLE_W-1:0] IDLE_S    = SAMPLE_W'(IDLE_SAMPLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STARVED
    } state_t;

    state_t                state_q, state_d;
    logic [OSR_LOG2-1:0]   phase_q, phase_d;
    logic [SAMPLE_W-1:0]   acc_q, acc_d;
    logic [SAMPLE_W-1:0]   cur_sample_q, cur_sample_d;
    logic                  rinc_q, rinc_d;
    logic                  rf_out_q, rf_out_d;
    logic [15:0]           count_q, count_d;
    logic                  sat_q, sat_d;

    logic                  bump;
    logic [SAMPLE_W-1:0]   raw_sample;
    logic [SAMPLE_W:0]     acc_sum;
    logic [SAMPLE_W:0]     acc_rem;

    logic unused_rdata_bits;
    assign unused_rdata_bits = ^fifo_rdata[DSIZE-1:SAMPLE_W];

    assign raw_sample = fifo_rdata[SAMPLE_W-1:0];

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 1'b1;
        rinc_d       = 1'b0;
        count_d      = count_q;
        sat_d        = sat_q;
        cur_sample_d = cur_sample_q;
        bump         = 1'b0;

        // Reads are only ever requested when the FIFO reports data, so rinc never hits an empty FIFO.
        if (phase_q == PH_DECIDE) begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && !fifo_rempty) begin
                        rinc_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (fifo_rempty) begin
                        state_d = ST_STARVED;
                        bump    = 1'b1;
                    end else begin
                        rinc_d = 1'b1;
                    end
                end
                ST_STARVED: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (fifo_rempty) begin
                        bump = 1'b1;
                    end else begin
                        rinc_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (bump && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        // A window with no read behind it plays the idle (mid-scale) sample.
        if (phase_q == PH_READ) begin
            if (rinc_q) begin
                if ({1'b0, raw_sample} > OSR_T) begin
                    cur_sample_d = OSR_T[SAMPLE_W-1:0];
                    sat_d        = 1'b1;
                end else begin
                    cur_sample_d = raw_sample;
                end
            end else begin
                cur_sample_d = IDLE_S;
            end
        end
    end

    // Error-feedback modulator: the residue stays below OSR, so each window emits exactly cur_sample ones.
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, cur_sample_q};
        rf_out_d = (acc_sum >= OSR_T);
        acc_rem  = rf_out_d ? (acc_sum - OSR_T) : acc_sum;
        acc_d    = acc_rem[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            acc_q        <= '0;
            cur_sample_q <= IDLE_S;
            rinc_q       <= 1'b0;
            rf_out_q     <= 1'b0;
            count_q      <= 16'd0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            cur_sample_q <= cur_sample_d;
            rinc_q       <= rinc_d;
            rf_out_q     <= rf_out_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
        end
    end

    assign fifo_rinc      = rinc_q;
    assign rf_out_1bit    = rf_out_q;
    assign running        = (state_q == ST_RUN);
    assign underrun_count = count_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_onebit_sdr_tx.sv
// Directed bench for onebit_sdr_tx: one table row per OSR window, checking the emitted
// bit pattern, read strobes, state and counters, plus async reset and mid-window disable.
module tb_onebit_sdr_tx;

    logic        clk_data = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic        fifo_rempty;
    logic [15:0] fifo_rdata;
    logic        fifo_rinc;
    logic        rf_out_1bit;
    logic        running;
    logic [15:0] underrun_count;
    logic        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // Simple FIFO model: words appear immediately, pop on the strobe edge.
    logic [15:0] mem_arr [64];
    int          wr_cnt = 0;
    int          rd_ptr = 0;

    assign fifo_rempty = (rd_ptr == wr_cnt);
    assign fifo_rdata  = mem_arr[rd_ptr[5:0]];

    always @(posedge clk_data or posedge rst) begin
        if (rst) rd_ptr <= wr_cnt;
        else if (fifo_rinc && (rd_ptr != wr_cnt)) rd_ptr <= rd_ptr + 1;
    end

    always #5 clk_data = ~clk_data;

    onebit_sdr_tx dut (
        .clk_data       (clk_data),
        .rst            (rst),
        .enable         (enable),
        .fifo_rempty    (fifo_rempty),
        .fifo_rdata     (fifo_rdata),
        .fifo_rinc      (fifo_rinc),
        .rf_out_1bit    (rf_out_1bit),
        .running        (running),
        .underrun_count (underrun_count),
        .sat_flag       (sat_flag)
    );

    typedef struct {
        logic        en;
        logic        push;
        logic [15:0] word;
        logic        drop;
        logic [3:0]  pat;
        int          rd;
        logic        run;
        logic [15:0] cnt;
        logic        sat;
    } step_t;

    step_t tbl [13];
    step_t post [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge inside phase 0; returns at the next phase-0 negedge.
    task automatic run_step(input step_t s, input string tag);
        logic [3:0] pat;
        int         rd;
        enable = s.en;
        if (s.push) begin
            mem_arr[wr_cnt[5:0]] = s.word;
            wr_cnt++;
        end
        pat = 4'b0000;
        rd  = 0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk_data);
            pat = {pat[2:0], rf_out_1bit};
            if (fifo_rinc) begin
                rd++;
                chk({tag, " rinc_while_empty"}, {31'd0, fifo_rempty}, 32'd0);
            end
            if (s.drop && j == 3) enable = 1'b0;
        end
        chk({tag, " pattern"}, {28'd0, pat}, {28'd0, s.pat});
        chk({tag, " reads"}, rd, s.rd);
        chk({tag, " running"}, {31'd0, running}, {31'd0, s.run});
        chk({tag, " underrun_count"}, {16'd0, underrun_count}, {16'd0, s.cnt});
        chk({tag, " sat_flag"}, {31'd0, sat_flag}, {31'd0, s.sat});
        $display("step %s: en=%0b pattern=%b reads=%0d running=%0b underruns=%0d sat=%0b",
                 tag, s.en, pat, rd, running, underrun_count, sat_flag);
    endtask

    initial begin
        //              en   push  word      drop  pat      rd run   cnt     sat
        tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'b0101, 1, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 4'b0000, 1, 1'b1, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 4'b1111, 1, 1'b1, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0101, 0, 1'b0, 16'd1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0101, 0, 1'b0, 16'd2, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h0003, 1'b0, 4'b0101, 1, 1'b1, 16'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0007, 1'b0, 4'b0111, 1, 1'b1, 16'd2, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 16'hFFE3, 1'b0, 4'b1111, 1, 1'b1, 16'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0111, 0, 1'b0, 16'd2, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0101, 0, 1'b0, 16'd2, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 16'h0004, 1'b0, 4'b0101, 0, 1'b0, 16'd2, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0101, 1, 1'b1, 16'd2, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 0, 1'b0, 16'd3, 1'b1};

        post[0] = '{1'b1, 1'b1, 16'h0002, 1'b0, 4'b0101, 1, 1'b1, 16'd0, 1'b0};
        post[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'b0101, 1, 1'b1, 16'd0, 1'b0};
        post[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 0, 1'b0, 16'd1, 1'b0};
        post[3] = '{1'b1, 1'b1, 16'h0004, 1'b1, 4'b0101, 1, 1'b1, 16'd1, 1'b0};
        post[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b1111, 0, 1'b0, 16'd1, 1'b0};
        post[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'b0101, 0, 1'b0, 16'd1, 1'b0};

        // Reset with the clock running.
        repeat (3) @(negedge clk_data);
        chk("reset rf_out", {31'd0, rf_out_1bit}, 32'd0);
        chk("reset rinc", {31'd0, fifo_rinc}, 32'd0);
        chk("reset underrun_count", {16'd0, underrun_count}, 32'd0);
        chk("reset running", {31'd0, running}, 32'd0);
        chk("reset sat_flag", {31'd0, sat_flag}, 32'd0);
        $display("reset: rf_out=%0b rinc=%0b running=%0b underruns=%0d",
                 rf_out_1bit, fifo_rinc, running, underrun_count);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_step(tbl[i], $sformatf("t%0d", i));
        end

        // Async reset between edges: outputs must clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async rf_out", {31'd0, rf_out_1bit}, 32'd0);
        chk("async rinc", {31'd0, fifo_rinc}, 32'd0);
        chk("async underrun_count", {16'd0, underrun_count}, 32'd0);
        chk("async running", {31'd0, running}, 32'd0);
        chk("async sat_flag", {31'd0, sat_flag}, 32'd0);
        $display("async reset: rf_out=%0b running=%0b underruns=%0d sat=%0b",
                 rf_out_1bit, running, underrun_count, sat_flag);
        enable = 1'b0;
        repeat (2) @(negedge clk_data);
        rst = 1'b0;

        // Restart from IDLE, starve, then drop enable mid-window.
        for (int i = 0; i < 6; i++) begin
            run_step(post[i], $sformatf("p%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
